// File: rtl/time_setter.sv
// time_setter: snapshots the live calendar digits, lets the user step through
// year..sec with BCD increment edits, then emits a one-cycle load strobe.
module time_setter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       inc,
  input  logic       next,
  input  logic       cancel,
  input  logic [3:0] cur_q0,
  input  logic [3:0] cur_q1,
  input  logic [3:0] cur_q2,
  input  logic [3:0] cur_q3,
  input  logic [3:0] cur_q4,
  input  logic [3:0] cur_q5,
  input  logic [3:0] cur_q6,
  input  logic [3:0] cur_q7,
  input  logic [3:0] cur_q8,
  input  logic [3:0] cur_q9,
  input  logic [3:0] cur_q10,
  input  logic [3:0] cur_q11,
  output logic [3:0] set_q0,
  output logic [3:0] set_q1,
  output logic [3:0] set_q2,
  output logic [3:0] set_q3,
  output logic [3:0] set_q4,
  output logic [3:0] set_q5,
  output logic [3:0] set_q6,
  output logic [3:0] set_q7,
  output logic [3:0] set_q8,
  output logic [3:0] set_q9,
  output logic [3:0] set_q10,
  output logic [3:0] set_q11,
  output logic       load_value_enable,
  output logic       editing,
  output logic [2:0] field_sel
);

  // Edit-state encodings equal the field_sel code shown to the display.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_YEAR   = 3'd1,
    S_MONTH  = 3'd2,
    S_DAY    = 3'd3,
    S_HOUR   = 3'd4,
    S_MIN    = 3'd5,
    S_SEC    = 3'd6,
    S_COMMIT = 3'd7
  } state_t;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v,
                                              input logic [7:0] v_max,
                                              input logic [7:0] v_min);
    logic [7:0] r;
    if (v >= v_max) begin
      r = v_min;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] day_max(input logic [7:0] month);
    logic [7:0] r;
    case (month)
      8'h02:                      r = 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sanitize(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] r;
    if (is_bcd(v) && (v >= lo) && (v <= hi)) begin
      r = v;
    end else begin
      r = lo;
    end
    return r;
  endfunction

  function automatic logic [7:0] clamp_day(input logic [7:0] day,
                                           input logic [7:0] month);
    logic [7:0] r;
    if (day > day_max(month)) begin
      r = day_max(month);
    end else begin
      r = day;
    end
    return r;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_year, r_month, r_day, r_hour, r_min, r_sec;
  logic [7:0] w_year_nxt, w_month_nxt, w_day_nxt, w_hour_nxt, w_min_nxt, w_sec_nxt;
  logic [7:0] w_snap_year, w_snap_month, w_snap_day, w_snap_hour, w_snap_min, w_snap_sec;
  logic [7:0] w_month_inc;
  logic       w_snap;
  logic       w_inc_act;
  logic       w_edit_nxt;
  logic       r_load_en;
  logic       r_editing;
  logic [2:0] r_field_sel;

  assign w_snap_year  = sanitize({cur_q11, cur_q10}, 8'h00, 8'h99);
  assign w_snap_month = sanitize({cur_q9, cur_q8}, 8'h01, 8'h12);
  assign w_snap_day   = clamp_day(sanitize({cur_q7, cur_q6}, 8'h01, 8'h31), w_snap_month);
  assign w_snap_hour  = sanitize({cur_q5, cur_q4}, 8'h00, 8'h23);
  assign w_snap_min   = sanitize({cur_q3, cur_q2}, 8'h00, 8'h59);
  assign w_snap_sec   = sanitize({cur_q1, cur_q0}, 8'h00, 8'h59);

  assign w_snap      = (r_state == S_IDLE) && set_req;
  assign w_inc_act   = inc && !cancel;
  assign w_month_inc = bcd_wrap_inc(r_month, 8'h12, 8'h01);

  // Next-state: cancel beats next; inc never blocks the advance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (set_req) w_state_nxt = S_YEAR;
        else         w_state_nxt = S_IDLE;
      end
      S_YEAR: begin
        if (cancel)    w_state_nxt = S_IDLE;
        else if (next) w_state_nxt = S_MONTH;
        else           w_state_nxt = S_YEAR;
      end
      S_MONTH: begin
        if (cancel)    w_state_nxt = S_IDLE;
        else if (next) w_state_nxt = S_DAY;
        else           w_state_nxt = S_MONTH;
      end
      S_DAY: begin
        if (cancel)    w_state_nxt = S_IDLE;
        else if (next) w_state_nxt = S_HOUR;
        else           w_state_nxt = S_DAY;
      end
      S_HOUR: begin
        if (cancel)    w_state_nxt = S_IDLE;
        else if (next) w_state_nxt = S_MIN;
        else           w_state_nxt = S_HOUR;
      end
      S_MIN: begin
        if (cancel)    w_state_nxt = S_IDLE;
        else if (next) w_state_nxt = S_SEC;
        else           w_state_nxt = S_MIN;
      end
      S_SEC: begin
        if (cancel)    w_state_nxt = S_IDLE;
        else if (next) w_state_nxt = S_COMMIT;
        else           w_state_nxt = S_SEC;
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Edit-register next values: snapshot in IDLE, else increment of the selected field.
  always_comb begin
    w_year_nxt  = r_year;
    w_month_nxt = r_month;
    w_day_nxt   = r_day;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;

    if (w_snap) w_year_nxt = w_snap_year;
    else if (w_inc_act && (r_state == S_YEAR)) w_year_nxt = bcd_wrap_inc(r_year, 8'h99, 8'h00);
    else w_year_nxt = r_year;

    if (w_snap) w_month_nxt = w_snap_month;
    else if (w_inc_act && (r_state == S_MONTH)) w_month_nxt = w_month_inc;
    else w_month_nxt = r_month;

    // A month change pulls the day down to the new month's maximum in the same cycle.
    if (w_snap) w_day_nxt = w_snap_day;
    else if (w_inc_act && (r_state == S_MONTH)) w_day_nxt = clamp_day(r_day, w_month_inc);
    else if (w_inc_act && (r_state == S_DAY)) w_day_nxt = bcd_wrap_inc(r_day, day_max(r_month), 8'h01);
    else w_day_nxt = r_day;

    if (w_snap) w_hour_nxt = w_snap_hour;
    else if (w_inc_act && (r_state == S_HOUR)) w_hour_nxt = bcd_wrap_inc(r_hour, 8'h23, 8'h00);
    else w_hour_nxt = r_hour;

    if (w_snap) w_min_nxt = w_snap_min;
    else if (w_inc_act && (r_state == S_MIN)) w_min_nxt = bcd_wrap_inc(r_min, 8'h59, 8'h00);
    else w_min_nxt = r_min;

    if (w_snap) w_sec_nxt = w_snap_sec;
    else if (w_inc_act && (r_state == S_SEC)) w_sec_nxt = bcd_wrap_inc(r_sec, 8'h59, 8'h00);
    else w_sec_nxt = r_sec;
  end

  // Status outputs are registered from the next state so they align with it.
  always_comb begin
    w_edit_nxt = 1'b0;
    case (w_state_nxt)
      S_YEAR, S_MONTH, S_DAY, S_HOUR, S_MIN, S_SEC: w_edit_nxt = 1'b1;
      default:                                      w_edit_nxt = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Edit registers; reset value is 00/01/01 00:00:00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_year  <= 8'h00;
      r_month <= 8'h01;
      r_day   <= 8'h01;
      r_hour  <= 8'h00;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
    end else begin
      r_year  <= w_year_nxt;
      r_month <= w_month_nxt;
      r_day   <= w_day_nxt;
      r_hour  <= w_hour_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
    end
  end

  // Registered strobe and display status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_en   <= 1'b0;
      r_editing   <= 1'b0;
      r_field_sel <= 3'd0;
    end else begin
      r_load_en   <= (w_state_nxt == S_COMMIT);
      r_editing   <= w_edit_nxt;
      r_field_sel <= w_edit_nxt ? w_state_nxt : 3'd0;
    end
  end

  assign set_q0  = r_sec[3:0];
  assign set_q1  = r_sec[7:4];
  assign set_q2  = r_min[3:0];
  assign set_q3  = r_min[7:4];
  assign set_q4  = r_hour[3:0];
  assign set_q5  = r_hour[7:4];
  assign set_q6  = r_day[3:0];
  assign set_q7  = r_day[7:4];
  assign set_q8  = r_month[3:0];
  assign set_q9  = r_month[7:4];
  assign set_q10 = r_year[3:0];
  assign set_q11 = r_year[7:4];

  assign load_value_enable = r_load_en;
  assign editing           = r_editing;
  assign field_sel         = r_field_sel;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: each step queues the expected outputs,
// clocks the stimulus, then pops and compares one cycle later.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_req, inc, next, cancel;
  logic [3:0] cur_q0, cur_q1, cur_q2, cur_q3, cur_q4, cur_q5;
  logic [3:0] cur_q6, cur_q7, cur_q8, cur_q9, cur_q10, cur_q11;
  logic [3:0] set_q0, set_q1, set_q2, set_q3, set_q4, set_q5;
  logic [3:0] set_q6, set_q7, set_q8, set_q9, set_q10, set_q11;
  logic       load_value_enable, editing;
  logic [2:0] field_sel;

  typedef struct packed {
    logic [47:0] q;
    logic        lve;
    logic        ed;
    logic [2:0]  fs;
  } exp_t;

  typedef struct packed {
    logic sr;
    logic i;
    logic n;
    logic c;
    exp_t e;
  } step_t;

  exp_t sb_q[$];
  exp_t obs;
  int   n_cmp = 0;
  int   n_err = 0;

  assign obs = {set_q11, set_q10, set_q9, set_q8, set_q7, set_q6,
                set_q5, set_q4, set_q3, set_q2, set_q1, set_q0,
                load_value_enable, editing, field_sel};

  time_setter dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .inc(inc), .next(next), .cancel(cancel),
    .cur_q0(cur_q0), .cur_q1(cur_q1), .cur_q2(cur_q2), .cur_q3(cur_q3),
    .cur_q4(cur_q4), .cur_q5(cur_q5), .cur_q6(cur_q6), .cur_q7(cur_q7),
    .cur_q8(cur_q8), .cur_q9(cur_q9), .cur_q10(cur_q10), .cur_q11(cur_q11),
    .set_q0(set_q0), .set_q1(set_q1), .set_q2(set_q2), .set_q3(set_q3),
    .set_q4(set_q4), .set_q5(set_q5), .set_q6(set_q6), .set_q7(set_q7),
    .set_q8(set_q8), .set_q9(set_q9), .set_q10(set_q10), .set_q11(set_q11),
    .load_value_enable(load_value_enable), .editing(editing), .field_sel(field_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] y, input logic [7:0] mo,
                                  input logic [7:0] d, input logic [7:0] h,
                                  input logic [7:0] mi, input logic [7:0] s,
                                  input logic lve, input logic ed, input logic [2:0] fs);
    exp_t e;
    e.q   = {y, mo, d, h, mi, s};
    e.lve = lve;
    e.ed  = ed;
    e.fs  = fs;
    return e;
  endfunction

  function automatic step_t mk_step(input logic sr, input logic i, input logic n,
                                    input logic c, input exp_t e);
    step_t s;
    s.sr = sr;
    s.i  = i;
    s.n  = n;
    s.c  = c;
    s.e  = e;
    return s;
  endfunction

  task automatic set_cur(input logic [7:0] y, input logic [7:0] mo, input logic [7:0] d,
                         input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    {cur_q11, cur_q10} = y;
    {cur_q9, cur_q8}   = mo;
    {cur_q7, cur_q6}   = d;
    {cur_q5, cur_q4}   = h;
    {cur_q3, cur_q2}   = mi;
    {cur_q1, cur_q0}   = s;
  endtask

  task automatic cyc(input logic sr, input logic i, input logic n, input logic c);
    @(negedge clk);
    set_req = sr;
    inc     = i;
    next    = n;
    cancel  = c;
    @(posedge clk);
    #1;
    set_req = 1'b0;
    inc     = 1'b0;
    next    = 1'b0;
    cancel  = 1'b0;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    rst_n = 1'b0;
    set_cur(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58);
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(mk_exp(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0));
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    st.push_back(mk_step(1'b0, 1'b1, 1'b1, 1'b0, e));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b1, e));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_idle step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_snapshot();
    step_t st[$];
    exp_t  e;
    set_cur(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0,
                 mk_exp(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd1)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL snapshot step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_year_wrap();
    step_t st[$];
    exp_t  e;
    set_cur(8'h11, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0,
                 mk_exp(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd1)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0,
                 mk_exp(8'h00, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd1)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL year_wrap step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_month_clamp();
    step_t st[$];
    exp_t  e;
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0,
                 mk_exp(8'h00, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd2)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0,
                 mk_exp(8'h00, 8'h01, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd2)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0,
                 mk_exp(8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd2)));
    for (int m = 3; m <= 12; m++)
      st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0,
                   mk_exp(8'h00, to_bcd(m), 8'h28, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd2)));
    for (int m = 1; m <= 4; m++)
      st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0,
                   mk_exp(8'h00, to_bcd(m), 8'h28, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd2)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL month_clamp step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_wraps();
    step_t st[$];
    exp_t  e;
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(8'h00, 8'h04, 8'h28, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd3)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h29, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd3)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h30, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd3)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd3)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd4)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h59, 8'h58, 1'b0, 1'b1, 3'd4)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h59, 8'h58, 1'b0, 1'b1, 3'd5)));
    for (int k = 0; k <= 10; k++)
      st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0,
                   mk_exp(8'h00, 8'h04, 8'h01, 8'h00, to_bcd(k), 8'h58, 1'b0, 1'b1, 3'd5)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h10, 8'h58, 1'b0, 1'b1, 3'd6)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h10, 8'h59, 1'b0, 1'b1, 3'd6)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1, 3'd6)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h10, 8'h00, 1'b1, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b0, mk_exp(8'h00, 8'h04, 8'h01, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 3'd0)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL wraps_commit step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t      st[$];
    exp_t       e;
    logic [7:0] y, mo, d, h, mi, s;
    {y, mo, d, h, mi, s} = {8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58};
    set_cur(y, mo, d, h, mi, s);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(y, mo, d, h, mi, s, 1'b0, 1'b1, 3'd1)));
    for (int f = 2; f <= 6; f++)
      st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(y, mo, d, h, mi, s, 1'b0, 1'b1, 3'(f))));
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, mk_exp(y, mo, d, h, mi, s, 1'b1, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(y, mo, d, h, mi, s, 1'b0, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b1, 1'b0, mk_exp(y, mo, d, h, mi, s, 1'b0, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(y, mo, d, h, mi, s, 1'b0, 1'b1, 3'd1)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b1, mk_exp(y, mo, d, h, mi, s, 1'b0, 1'b0, 3'd0)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL back_to_back step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_cancel();
    step_t st[$];
    exp_t  e;
    set_cur(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'd1)));
    for (int f = 2; f <= 4; f++)
      st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0,
                   mk_exp(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 3'(f))));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h99, 8'h12, 8'h31, 8'h00, 8'h59, 8'h58, 1'b0, 1'b1, 3'd4)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b1, mk_exp(8'h99, 8'h12, 8'h31, 8'h00, 8'h59, 8'h58, 1'b0, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b0, mk_exp(8'h99, 8'h12, 8'h31, 8'h00, 8'h59, 8'h58, 1'b0, 1'b0, 3'd0)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL cancel step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_priority();
    step_t st[$];
    exp_t  e;
    set_cur(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h30);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h30, 1'b0, 1'b1, 3'd1)));
    for (int f = 2; f <= 5; f++)
      st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0,
                   mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h30, 1'b0, 1'b1, 3'(f))));
    st.push_back(mk_step(1'b0, 1'b1, 1'b1, 1'b0, mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h06, 8'h30, 1'b0, 1'b1, 3'd6)));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b1, mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h06, 8'h30, 1'b0, 1'b0, 3'd0)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b0, mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h06, 8'h30, 1'b0, 1'b0, 3'd0)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL priority step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_sanitize();
    step_t st[$];
    exp_t  e;
    set_cur(8'h07, 8'h13, 8'h00, 8'h27, 8'h60, 8'h0C);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(8'h07, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1)));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b1, mk_exp(8'h07, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL sanitize step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
  endtask

  task automatic test_reset_mid_edit();
    step_t st[$];
    exp_t  e;
    exp_t  e_rst;
    e_rst = mk_exp(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    set_cur(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h30);
    st.push_back(mk_step(1'b1, 1'b0, 1'b0, 1'b0, mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h30, 1'b0, 1'b1, 3'd1)));
    for (int f = 2; f <= 6; f++)
      st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0,
                   mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h30, 1'b0, 1'b1, 3'(f))));
    st.push_back(mk_step(1'b0, 1'b1, 1'b0, 1'b0, mk_exp(8'h25, 8'h03, 8'h15, 8'h10, 8'h05, 8'h31, 1'b0, 1'b1, 3'd6)));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mid_reset_setup step %0d: got q=%h lve=%b ed=%b fs=%0d want q=%h lve=%b ed=%b fs=%0d",
                 k, obs.q, obs.lve, obs.ed, obs.fs, e.q, e.lve, e.ed, e.fs);
      end
    end
    // Assert reset between edges, then pulse next while still in reset.
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(e_rst);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL mid_reset_immediate: got %h want %h", obs, e);
    end
    st.delete();
    st.push_back(mk_step(1'b0, 1'b0, 1'b1, 1'b0, e_rst));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mid_reset_held step %0d: got %h want %h", k, obs, e);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    st.delete();
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b0, e_rst));
    st.push_back(mk_step(1'b0, 1'b0, 1'b0, 1'b0, e_rst));
    for (int k = 0; k < st.size(); k++) begin
      sb_q.push_back(st[k].e);
      cyc(st[k].sr, st[k].i, st[k].n, st[k].c);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mid_reset_release step %0d: got %h want %h", k, obs, e);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    set_req = 1'b0;
    inc     = 1'b0;
    next    = 1'b0;
    cancel  = 1'b0;
    set_cur(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_snapshot();
    test_year_wrap();
    test_month_clamp();
    test_wraps();
    test_back_to_back();
    test_cancel();
    test_priority();
    test_sanitize();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
